// File: rtl/imm_gen_pkg.sv
// Shared definitions for the RISC-V immediate generator: format codes and
// the major opcodes the decoder recognises.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FUNCT3_SLLI = 3'b001;
  localparam logic [2:0] FUNCT3_SRXI = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational decode of one instruction word into its extended
// immediate, format code and illegal flag.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [31:0] imm32;
  logic [2:0]  funct3;

  assign funct3 = instr[14:12];

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    imm32   = '0;
    fmt     = FMT_ILL;
    illegal = 1'b0;
    case (instr[6:0])
      OP_LOAD, OP_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_OP_IMM: begin
        fmt = FMT_I;
        if (funct3 == FUNCT3_SLLI || funct3 == FUNCT3_SRXI) begin
          // RV64 shifts carry a 6-bit shamt, RV32 only 5 bits.
          imm32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
        end else begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_OP: begin
        fmt = FMT_R;
      end
      OP_SYSTEM: begin
        // CSR immediate forms carry a zero-extended uimm in the rs1 field.
        if (funct3[2]) begin
          fmt   = FMT_Z;
          imm32 = {27'b0, instr[19:15]};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      default: begin
        fmt     = FMT_ILL;
        illegal = 1'b1;
      end
    endcase
  end

  // Zero-extended fields are small positives, so one signed widening serves all.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry in-order output buffer, valid/ready
// handshakes on both sides and a saturating illegal-instruction counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instruction_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_illegal;
  entry_t           dec;
  entry_t           mem [2];
  entry_t           head_q;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count, count_next;
  logic             ready_q;
  logic             push, pop;
  logic [CNT_W-1:0] ill_cnt_q;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instruction_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec     = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal};
  assign valid_o = (count != 2'd0);
  assign push    = valid_i & ready_q;
  assign pop     = valid_o & ready_i;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 2'd1;
    else if (pop && !push) count_next = count - 2'd1;
  end

  // NOTE: the slots need no reset; count alone says which ones hold data.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      ready_q   <= 1'b0;
      head_q    <= '0;
      ill_cnt_q <= '0;
    end else begin
      count   <= count_next;
      // Registered from the next occupancy, so ready_o never sees ready_i combinationally.
      ready_q <= (count_next != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;

      // The head copy only moves when the head itself changes; when the
      // buffer drains it keeps the last head values.
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        head_q <= dec;
      end else if (pop && count == 2'd2) begin
        head_q <= mem[~rd_ptr];
      end

      if (push && dec_illegal && ill_cnt_q != '1) begin
        ill_cnt_q <= ill_cnt_q + CNT_W'(1);
      end
    end
  end

  assign ready_o       = ready_q;
  assign imm_o         = head_q.imm;
  assign fmt_o         = head_q.fmt;
  assign illegal_o     = head_q.illegal;
  assign illegal_cnt_o = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance
// share stimulus and are compared against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, ready_i;
  logic [31:0] instruction_i;

  logic        ready_o, valid_o, illegal_o;
  logic [31:0] imm_o;
  logic [2:0]  fmt_o;
  logic [7:0]  illegal_cnt_o;

  logic        ready64, valid64, illegal64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  cnt64;

  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .instruction_i(instruction_i), .valid_o(valid_o), .ready_i(ready_i),
    .imm_o(imm_o), .fmt_o(fmt_o), .illegal_o(illegal_o), .illegal_cnt_o(illegal_cnt_o)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready64),
    .instruction_i(instruction_i), .valid_o(valid64), .ready_i(ready_i),
    .imm_o(imm64), .fmt_o(fmt64), .illegal_o(illegal64), .illegal_cnt_o(cnt64)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t last_head;
  bit   armed;
  int   cnt_m;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference decode straight from the format rules, computed at 64 bits.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t   e;
    longint v = 0;
    e.fmt = 3'd7;
    e.ill = 1'b0;
    case (w[6:0])
      7'h03, 7'h67: begin e.fmt = 3'd1; v = longint'($signed(w[31:20])); end
      7'h13: begin
        e.fmt = 3'd1;
        v = longint'($signed(w[31:20]));
      end
      7'h23: begin e.fmt = 3'd2; v = longint'($signed({w[31:25], w[11:7]})); end
      7'h63: begin e.fmt = 3'd3; v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); end
      7'h37, 7'h17: begin e.fmt = 3'd4; v = longint'($signed({w[31:12], 12'b0})); end
      7'h6F: begin e.fmt = 3'd5; v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
      7'h33: begin e.fmt = 3'd0; v = 0; end
      7'h73: begin
        if (w[14]) begin e.fmt = 3'd6; v = longint'(w[19:15]); end
        else begin e.fmt = 3'd1; v = longint'($signed(w[31:20])); end
      end
      default: begin e.fmt = 3'd7; e.ill = 1'b1; v = 0; end
    endcase
    e.imm64 = v;
    e.imm32 = v[31:0];
    if (w[6:0] == 7'h13 && (w[14:12] == 3'b001 || w[14:12] == 3'b101)) begin
      e.imm64 = {58'b0, w[25:20]};
      e.imm32 = {27'b0, w[24:20]};
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  task automatic clear_model();
    q.delete();
    last_head = '{imm32: '0, imm64: '0, fmt: '0, ill: 1'b0};
    armed = 1'b0;
    cnt_m = 0;
  endtask

  task automatic check_outputs();
    exp_t h;
    if (q.size() != 0) last_head = q[0];
    h = last_head;
    check("valid_o", valid_o, q.size() != 0);
    check("ready_o", ready_o, armed && q.size() < 2);
    check("imm_o", imm_o, h.imm32);
    check("fmt_o", fmt_o, h.fmt);
    check("illegal_o", illegal_o, h.ill);
    check("illegal_cnt_o", illegal_cnt_o, cnt_m);
    check("valid64", valid64, q.size() != 0);
    check("ready64", ready64, armed && q.size() < 2);
    check("imm64", imm64, h.imm64);
    check("fmt64", fmt64, h.fmt);
    check("cnt64", cnt64, cnt_m);
  endtask

  // Drive at the falling edge, let one rising edge act, check at the next falling edge.
  task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic r);
    bit   push, pop;
    exp_t e;
    valid_i = v; instruction_i = ins; ready_i = r;
    push = v && armed && (q.size() < 2);
    pop  = (q.size() != 0) && r;
    @(posedge clk_i);
    armed = 1'b1;
    if (pop) q.delete(0);
    if (push) begin
      e = ref_decode(ins);
      q.push_back(e);
      if (e.ill && cnt_m < 255) cnt_m++;
    end
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, valid_o, 1'b0);
    check({tag, "_ready"}, ready_o, 1'b0);
    check({tag, "_imm"}, imm_o, 32'h0);
    check({tag, "_fmt"}, fmt_o, 3'd0);
    check({tag, "_ill"}, illegal_o, 1'b0);
    check({tag, "_cnt"}, illegal_cnt_o, 8'd0);
    check({tag, "_valid64"}, valid64, 1'b0);
    check({tag, "_ready64"}, ready64, 1'b0);
    check({tag, "_imm64"}, imm64, 64'h0);
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; instruction_i = '0;
    clear_model();
    repeat (2) @(negedge clk_i);
    check_reset_state("rst_hold");
    rst_i = 1'b1;
    drive_cycle(1'b0, 32'h0, 1'b1);
    check("rst_release_ready", ready_o, 1'b1);

    // addi x1,x0,-1
    drive_cycle(1'b1, 32'hFFF00093, 1'b1);
    check("addi_valid", valid_o, 1'b1);
    check("addi_imm", imm_o, 32'hFFFFFFFF);
    check("addi_fmt", fmt_o, 3'd1);

    // Back-to-back S, B, U
    drive_cycle(1'b1, 32'hFE112E23, 1'b1);
    check("s_imm", imm_o, 32'hFFFFFFFC);
    check("s_fmt", fmt_o, 3'd2);
    drive_cycle(1'b1, 32'hFE000CE3, 1'b1);
    check("b_imm", imm_o, 32'hFFFFFFF8);
    check("b_fmt", fmt_o, 3'd3);
    drive_cycle(1'b1, 32'h123450B7, 1'b1);
    check("u_imm", imm_o, 32'h12345000);
    check("u_fmt", fmt_o, 3'd4);
    drive_cycle(1'b0, 32'h0, 1'b1);
    check("drain_hold_imm", imm_o, 32'h12345000);

    // Backpressure: three offers with ready_i low, then drain
    drive_cycle(1'b1, 32'h00100093, 1'b0);
    drive_cycle(1'b1, 32'h00200093, 1'b0);
    check("full_ready", ready_o, 1'b0);
    drive_cycle(1'b1, 32'h00300093, 1'b0);
    check("full_stall_imm", imm_o, 32'h1);
    drive_cycle(1'b1, 32'h00300093, 1'b1);
    check("full_pop1_imm", imm_o, 32'h2);
    check("full_pop1_ready", ready_o, 1'b1);
    drive_cycle(1'b1, 32'h00300093, 1'b1);
    check("full_third_imm", imm_o, 32'h3);
    drive_cycle(1'b0, 32'h0, 1'b1);

    // Shift amount and LUI sign extension on both widths
    drive_cycle(1'b1, 32'h01F09093, 1'b1);
    check("slli_imm64", imm64, 64'h000000000000001F);
    check("slli_imm32", imm_o, 32'h1F);
    drive_cycle(1'b1, 32'h80000037, 1'b1);
    check("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    check("lui_imm32", imm_o, 32'h80000000);

    // Counter saturation
    for (int i = 0; i < 300; i++) drive_cycle(1'b1, 32'h0000007F, 1'b1);
    check("sat_ill", illegal_o, 1'b1);
    check("sat_imm", imm_o, 32'h0);
    check("sat_cnt", illegal_cnt_o, 8'd255);

    // Reset with two entries held
    drive_cycle(1'b0, 32'h0, 1'b1);
    drive_cycle(1'b1, 32'h00500093, 1'b0);
    drive_cycle(1'b1, 32'h00600093, 1'b0);
    check("pre_rst_valid", valid_o, 1'b1);
    rst_i = 1'b0;
    #1;
    clear_model();
    check_reset_state("rst_mid");
    @(posedge clk_i);
    @(negedge clk_i);
    check_reset_state("rst_mid_hold");
    rst_i = 1'b1;
    drive_cycle(1'b0, 32'h0, 1'b1);
    check("post_rst_valid", valid_o, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
